// File: rtl/ping_pong_pkg.sv
// Shared definitions for the ping-pong counter and its monitor: FSM states,
// the (value, direction) pair, the step rule and the counter's reset pair.
package ping_pong_pkg;

    typedef enum logic [1:0] {ACQ, RESYNC, TRACK} pp_state_t;

    typedef struct packed {
        logic [31:0] v;
        logic        d;
    } pp_pair_t;

    localparam pp_pair_t PP_RESET_PAIR = '{v: 32'd0, d: 1'b1};

    // One counter step; maxv is the top of the range. Values wrap modulo
    // maxv+1, so stepping from an illegal pair is still well defined.
    function automatic pp_pair_t pp_step(input logic [31:0] v, input logic d,
                                         input logic [31:0] maxv);
        pp_pair_t n;
        if (d) begin
            n.v = (v == maxv) ? 32'd0 : v + 32'd1;
            n.d = (n.v != maxv);
        end else begin
            n.v = (v == 32'd0) ? maxv : v - 32'd1;
            n.d = (n.v == 32'd0);
        end
        return n;
    endfunction

endpackage

// File: rtl/ping_pong_monitor_if.sv
// Observation bundle between the ping-pong counter side and its monitor.
interface ping_pong_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             enable;
    logic             direction;
    logic [WIDTH-1:0] in;
    logic             locked;
    logic             error;
    logic [WIDTH-1:0] expected;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bounce_count;

    modport master (
        output enable, direction, in,
        input  locked, error, expected, err_count, bounce_count
    );

    modport slave (
        input  enable, direction, in,
        output locked, error, expected, err_count, bounce_count
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that either saturates at all-ones or wraps, selected by sat_en.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         inc,
    input  logic         sat_en,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else if (inc && !(sat_en && (&count))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ping_pong_monitor.sv
// Passive checker for the ping-pong counter: predicts each sample from the
// previous one, flags violations, counts turnarounds and reports lock.
module ping_pong_monitor
    import ping_pong_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int RELOCK = 2,
    parameter int CNT_W  = 8
) (
    input logic                CLK,
    input logic                RESET,
    ping_pong_monitor_if.slave bus
);

    localparam logic [31:0] MAXV = 32'(2 ** WIDTH - 1);
    localparam int          RC_W = (RELOCK > 1) ? $clog2(RELOCK + 1) : 1;

    pp_state_t        state, state_nxt;
    logic [RC_W-1:0]  rcnt, rcnt_nxt;
    logic [WIDTH-1:0] ref_v;
    logic             ref_d;
    logic             ref_en;
    pp_pair_t         pred;
    logic [31:0]      in_w;
    logic             illegal;
    logic             match;
    logic             error_nxt;
    logic             bounce_inc;

    // Prediction: the reference advances only if enable was high when it was taken.
    always_comb begin
        in_w = 32'(bus.in);
        if (ref_en) begin
            pred = pp_step(32'(ref_v), ref_d, MAXV);
        end else begin
            pred.v = 32'(ref_v);
            pred.d = ref_d;
        end
        illegal = ((in_w == MAXV) && bus.direction) || ((in_w == 32'd0) && !bus.direction);
        match   = !illegal && (in_w == pred.v) && (bus.direction == pred.d);
    end

    always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        error_nxt  = 1'b0;
        bounce_inc = 1'b0;
        unique case (state)
            ACQ: begin
                state_nxt = RESYNC;
                rcnt_nxt  = '0;
            end
            RESYNC: begin
                if (!match) begin
                    rcnt_nxt = '0;
                end else if (rcnt == RC_W'(RELOCK - 1)) begin
                    state_nxt = TRACK;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            TRACK: begin
                if (!match) begin
                    error_nxt = 1'b1;
                    state_nxt = RESYNC;
                    rcnt_nxt  = '0;
                end else if (ref_en && ((in_w == 32'd0) || (in_w == MAXV))) begin
                    bounce_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ACQ;
                rcnt_nxt  = '0;
            end
        endcase
    end

    // The reference always follows the observed stream so a resync lands on reality.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ACQ;
            rcnt         <= '0;
            ref_v        <= PP_RESET_PAIR.v[WIDTH-1:0];
            ref_d        <= PP_RESET_PAIR.d;
            ref_en       <= 1'b0;
            bus.error    <= 1'b0;
            bus.locked   <= 1'b0;
            bus.expected <= '0;
        end else begin
            state        <= state_nxt;
            rcnt         <= rcnt_nxt;
            ref_v        <= bus.in;
            ref_d        <= bus.direction;
            ref_en       <= bus.enable;
            bus.error    <= error_nxt;
            bus.locked   <= (state_nxt == TRACK);
            bus.expected <= pred.v[WIDTH-1:0];
        end
    end

    sat_counter #(.W(CNT_W)) u_err_count (
        .CLK    (CLK),
        .RESET  (RESET),
        .inc    (error_nxt),
        .sat_en (1'b1),
        .count  (bus.err_count)
    );

    sat_counter #(.W(CNT_W)) u_bounce_count (
        .CLK    (CLK),
        .RESET  (RESET),
        .inc    (bounce_inc),
        .sat_en (1'b0),
        .count  (bus.bounce_count)
    );

endmodule

// File: tb/tb_ping_pong_monitor.sv
// Scoreboard bench for ping_pong_monitor: a behavioural model predicts every
// registered output; a monitor process compares them one cycle at a time.
module tb_ping_pong_monitor;

    localparam int RELOCK = 2;
    localparam int VMAX   = 15;
    localparam int CMAX   = 255;

    logic CLK;
    logic RESET;

    ping_pong_monitor_if #(.WIDTH(4), .CNT_W(8)) bus ();

    ping_pong_monitor #(.WIDTH(4), .RELOCK(RELOCK), .CNT_W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int lk;
        int er;
        int ex;
        bit chk_ex;
        int ec;
        int bc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit m_acq = 1'b1;
    bit m_locked = 1'b0;
    int m_cnt = 0;
    int m_ec = 0;
    int m_bc = 0;
    int pv = 0, pd = 1, pe = 0;

    // behavioural counter being observed
    int cv = 0, cd = 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int step_v(input int v, input int d);
        return d ? (v + 1) % (VMAX + 1) : (v + VMAX) % (VMAX + 1);
    endfunction

    function automatic int step_d(input int v, input int d);
        int nv;
        nv = step_v(v, d);
        return d ? int'(nv != VMAX) : int'(nv == 0);
    endfunction

    // Computes what the monitor must show after the edge that samples these inputs.
    task automatic model_step(input bit rst, input bit e, input int d, input int v);
        exp_t x;
        int   qv, qd;
        bit   ok;
        x.chk_ex = 1'b1;
        x.er = 0;
        x.ex = 0;
        if (rst) begin
            m_acq = 1'b1; m_locked = 1'b0; m_cnt = 0; m_ec = 0; m_bc = 0;
            pv = 0; pd = 1; pe = 0;
        end else if (m_acq) begin
            m_acq = 1'b0; m_cnt = 0; m_locked = 1'b0;
            x.chk_ex = 1'b0;
            pv = v; pd = d; pe = e;
        end else begin
            qv = pe ? step_v(pv, pd) : pv;
            qd = pe ? step_d(pv, pd) : pd;
            ok = (v == qv) && (d == qd) && !((v == VMAX && d == 1) || (v == 0 && d == 0));
            x.ex = qv;
            if (m_locked) begin
                if (!ok) begin
                    x.er = 1;
                    if (m_ec < CMAX) m_ec++;
                    m_locked = 1'b0;
                    m_cnt = 0;
                end else if (pe && (v == 0 || v == VMAX)) begin
                    m_bc = (m_bc + 1) % (CMAX + 1);
                end
            end else if (ok) begin
                m_cnt++;
                if (m_cnt == RELOCK) begin
                    m_locked = 1'b1;
                    m_cnt = 0;
                end
            end else begin
                m_cnt = 0;
            end
            pv = v; pd = d; pe = e;
        end
        x.lk = m_locked;
        x.ec = m_ec;
        x.bc = m_bc;
        sb_q.push_back(x);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input bit rst, input bit e, input int v, input int d);
        logic [3:0] vv;
        vv = v[3:0];
        RESET = rst;
        bus.enable = e;
        bus.direction = d[0];
        bus.in = vv;
        model_step(rst, e, d, v);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic tick(input bit rst, input bit e, input bit glitch, input int gv, input int gd);
        int nv, nd;
        if (glitch) drive(rst, e, gv, gd);
        else        drive(rst, e, cv, cd);
        if (e) begin
            nv = step_v(cv, cd);
            nd = step_d(cv, cd);
            cv = nv;
            cd = nd;
        end
    endtask

    task automatic run_to(input int v, input int d);
        int n;
        n = 0;
        while (!(cv == v && cd == d) && n < 40) begin
            tick(0, 1, 0, 0, 0);
            n++;
        end
        check("reach_value", int'(cv == v && cd == d), 1);
    endtask

    always @(posedge CLK) begin
        exp_t x;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("locked", int'(bus.locked), x.lk);
            check("error", int'(bus.error), x.er);
            if (x.chk_ex) check("expected", int'(bus.expected), x.ex);
            check("err_count", int'(bus.err_count), x.ec);
            check("bounce_count", int'(bus.bounce_count), x.bc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_bc;
        RESET = 1'b1;
        bus.enable = 1'b0;
        bus.direction = 1'b1;
        bus.in = '0;
        @(negedge CLK);

        // free-running stream from counter reset
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, 0, 0, 0);
            if (i == 3) check("first_lock_by_edge4", int'(bus.locked), 1);
        end
        check("bounce_after_40", int'(bus.bounce_count), 2);
        check("no_errors_after_40", int'(bus.err_count), 0);

        // enable held low at 7 going up
        run_to(7, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0);
            check("stall_expected", int'(bus.expected), 7);
            check("stall_error", int'(bus.error), 0);
        end
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        check("resume_expected", int'(bus.expected), 8);

        // counter jumps to 9 where 5 was expected
        run_to(5, 1);
        cv = 9;
        cd = 1;
        tick(0, 1, 0, 0, 0);
        check("jump_error", int'(bus.error), 1);
        check("jump_err_count", int'(bus.err_count), 1);
        check("jump_unlocked", int'(bus.locked), 0);
        tick(0, 1, 0, 0, 0);
        check("jump_relock_wait", int'(bus.locked), 0);
        tick(0, 1, 0, 0, 0);
        check("jump_relocked", int'(bus.locked), 1);

        // illegal (15,1) in place of a real turnaround
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
        saved_bc = int'(bus.bounce_count);
        tick(0, 1, 1, VMAX, 1);
        check("illegal_error", int'(bus.error), 1);
        check("illegal_bounce_unchanged", int'(bus.bounce_count), saved_bc);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 0);

        // glitch train driving err_count into saturation
        for (int i = 0; i < 300; i++) begin
            tick(0, 1, 1, VMAX - cv, cd);
            for (int j = 0; j < 3; j++) tick(0, 1, 0, 0, 0);
        end
        check("saturated_err_count", int'(bus.err_count), CMAX);
        tick(0, 1, 1, VMAX - cv, cd);
        check("error_at_saturation", int'(bus.error), 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);

        // random enables and random corrupt samples
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0)
                tick(0, ($urandom_range(0, 3) != 0), 1, $urandom_range(0, 15), $urandom_range(0, 1));
            else
                tick(0, ($urandom_range(0, 3) != 0), 0, 0, 0);
        end

        // one-cycle reset mid-stream at 12
        run_to(12, 1);
        tick(1, 1, 0, 0, 0);
        check("reset_locked", int'(bus.locked), 0);
        check("reset_error", int'(bus.error), 0);
        check("reset_expected", int'(bus.expected), 0);
        check("reset_err_count", int'(bus.err_count), 0);
        check("reset_bounce_count", int'(bus.bounce_count), 0);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 0);
        check("reacquired_locked", int'(bus.locked), 1);
        check("reacquired_no_error", int'(bus.err_count), 0);

        tick(0, 1, 0, 0, 0);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
